ucie_ctl_rx_top: RTL and testbench

//  Receive-path controller between the RDI (adapter-to-PHY) and FDI (protocol-facing) interfaces.

---
 rtl/ucie_ctl_rx_pkg.sv | 12 +
 rtl/ucie_ctl_rx_fifo.sv | 63 ++++++
 rtl/ucie_ctl_rx_top.sv | 95 +++++++++
 tb/tb_ucie_ctl_rx_top.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_rx_pkg.sv
// Shared types and defaults for the UCIe receive-path controller.
package ucie_ctl_rx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ctl_state_t;

  localparam int DEFAULT_NBYTES = 32;
  localparam int DEFAULT_DEPTH  = 32;

endpackage

// File: rtl/ucie_ctl_rx_fifo.sv
// Elastic buffer between RDI capture and FDI forwarding.
// The head word is presented combinationally and the buffer can be flushed synchronously.
module ucie_ctl_rx_fifo
  import ucie_ctl_rx_pkg::*;
#(
  parameter int NBYTES = DEFAULT_NBYTES,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wr_en,
  input  logic [NBYTES-1:0] wr_data,
  input  logic              rd_en,
  output logic [NBYTES-1:0] rd_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [NBYTES-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              push;
  logic              pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // A flush wins over any access issued in the same cycle.
  assign push = wr_en && !full && !flush;
  assign pop  = rd_en && !empty && !flush;

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ucie_ctl_rx_top.sv
// Receive-path controller: captures RDI words into a buffer while ACTIVE and
// forwards them to the FDI on cycles without incoming data.
module ucie_ctl_rx_top
  import ucie_ctl_rx_pkg::*;
#(
  parameter int NBYTES = DEFAULT_NBYTES,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_state_request,
  input  logic [NBYTES-1:0] i_rdi_pl_data,
  input  logic              i_rdi_pl_valid,
  output logic [NBYTES-1:0] o_fdi_data,
  output logic              o_fdi_data_valid,
  output logic              o_overflow_detected
);

  localparam int CW = $clog2(DEPTH + 1);

  ctl_state_t        state_reg;
  ctl_state_t        state_next;
  logic              wr_en;
  logic              rd_en;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [NBYTES-1:0] fifo_head;
  logic              has_data;

  assign has_data = !fifo_empty && (fifo_count != '0);

  ucie_ctl_rx_fifo #(
    .NBYTES (NBYTES),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (wr_en),
    .wr_data (i_rdi_pl_data),
    .rd_en   (rd_en),
    .rd_data (fifo_head),
    .flush   (flush),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Incoming data has priority, so a read only happens on an idle input cycle.
  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    flush      = 1'b0;
    case (state_reg)
      IDLE: begin
        flush = 1'b1;
        if (i_state_request) state_next = ACTIVE;
      end
      ACTIVE: begin
        wr_en = i_rdi_pl_valid;
        rd_en = !i_rdi_pl_valid && has_data;
        if (!i_state_request) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fdi_data          <= '0;
      o_fdi_data_valid    <= 1'b0;
      o_overflow_detected <= 1'b0;
    end else begin
      o_fdi_data_valid <= rd_en;
      if (rd_en) o_fdi_data <= fifo_head;
      if (flush) begin
        o_overflow_detected <= 1'b0;
      end else if (wr_en && fifo_full) begin
        o_overflow_detected <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ucie_ctl_rx_top.sv
// Directed and randomized checks of ucie_ctl_rx_top against a queue-based reference model.
module tb_ucie_ctl_rx_top;

  localparam int NB    = 32;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          vld;
  logic [NB-1:0] din;
  logic [NB-1:0] fdi_data;
  logic          fdi_valid;
  logic          ovf;

  ucie_ctl_rx_top #(.NBYTES(NB), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_state_request     (req),
    .i_rdi_pl_data       (din),
    .i_rdi_pl_valid      (vld),
    .o_fdi_data          (fdi_data),
    .o_fdi_data_valid    (fdi_valid),
    .o_overflow_detected (ovf)
  );

  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            out_words;
  bit            m_active;
  bit            m_valid;
  bit            m_ovf;
  logic [NB-1:0] m_data;
  logic [NB-1:0] q[$];

  task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_data   = '0;
  endtask

  // One clock edge of the link: behaviour depends on the state held before the edge.
  task automatic model_edge();
    if (m_active) begin
      m_valid = 1'b0;
      if (vld) begin
        if (q.size() == DEPTH) m_ovf = 1'b1;
        else q.push_back(din);
      end else if (q.size() > 0) begin
        m_data  = q.pop_front();
        m_valid = 1'b1;
      end
    end else begin
      q.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
    m_active = req;
  endtask

  task automatic cycle(input bit r, input bit v, input logic [NB-1:0] d);
    req = r;
    vld = v;
    din = d;
    @(posedge clk);
    model_edge();
    #1;
    check("fdi_valid", {31'b0, fdi_valid}, {31'b0, m_valid});
    check("fdi_data", fdi_data, m_data);
    check("overflow", {31'b0, ovf}, {31'b0, m_ovf});
    if (fdi_valid) out_words++;
    $display("cyc t=%0t req=%0b vld=%0b din=%h -> valid=%0b data=%h ovf=%0b", $time, r, v, d,
             fdi_valid, fdi_data, ovf);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", {31'b0, fdi_valid}, 32'd0);
    check("rst_data", fdi_data, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    vld = 1'b0;
    din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("init_valid", {31'b0, fdi_valid}, 32'd0);
    check("init_data", fdi_data, 32'd0);

    // Single word
    out_words = 0;
    cycle(1, 0, '0);
    cycle(1, 1, 32'hA5);
    cycle(1, 0, '0);
    cycle(1, 0, '0);
    check("single_count", out_words, 32'd1);

    // Burst ordering
    out_words = 0;
    for (int i = 1; i <= 3; i++) cycle(1, 1, NB'(i));
    repeat (4) cycle(1, 0, '0);
    check("burst_count", out_words, 32'd3);

    // Overflow: 33 writes into an empty buffer, then drain
    for (int i = 0; i < DEPTH + 1; i++) cycle(1, 1, NB'(32'h100 + i));
    out_words = 0;
    repeat (DEPTH + 2) cycle(1, 0, '0);
    check("ovf_drain_count", out_words, 32'd32);

    // Flush on IDLE with overflow still set
    for (int i = 0; i < 5; i++) cycle(1, 1, NB'(32'h200 + i));
    out_words = 0;
    cycle(0, 1, 32'hBEEF);
    repeat (3) cycle(0, 0, '0);
    repeat (4) cycle(1, 0, '0);
    check("flush_count", out_words, 32'd0);

    // Input ignored while IDLE
    cycle(0, 0, '0);
    out_words = 0;
    repeat (4) cycle(0, 1, 32'hDEAD);
    check("idle_ignore_count", out_words, 32'd0);

    // Reset in the middle of traffic
    for (int i = 0; i < 4; i++) cycle(1, 1, NB'(32'h300 + i));
    cycle(1, 0, '0);
    mid_reset();
    cycle(0, 0, '0);
    cycle(1, 0, '0);
    cycle(1, 0, '0);

    // Randomized traffic with alternating write pressure
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 85 : 30;
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(0, 24) != 0), ($urandom_range(0, 99) < wp), $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
